// File: rtl/ffre_pkg.sv
// ffre_bank shared definitions: config word layout and polarity constants.
// Field widths derive from the bank's NSRC/NENA/NCLR parameters.
package ffre_pkg;

  localparam logic POL_HIGH = 1'b1;
  localparam logic POL_LOW  = 1'b0;

  // A one-entry select still gets a 1-bit field so the word never has a zero-width slice.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int src_off();
    return 0;
  endfunction

  function automatic int ena_use_off(input int nsrc);
    return sel_w(nsrc);
  endfunction

  function automatic int ena_pol_off(input int nsrc);
    return ena_use_off(nsrc) + 1;
  endfunction

  function automatic int ena_sel_off(input int nsrc);
    return ena_use_off(nsrc) + 2;
  endfunction

  function automatic int clr_use_off(input int nsrc, input int nena);
    return ena_sel_off(nsrc) + sel_w(nena);
  endfunction

  function automatic int clr_pol_off(input int nsrc, input int nena);
    return clr_use_off(nsrc, nena) + 1;
  endfunction

  function automatic int clr_sel_off(input int nsrc, input int nena);
    return clr_use_off(nsrc, nena) + 2;
  endfunction

  function automatic int cfg_w(input int nsrc, input int nena, input int nclr);
    return clr_sel_off(nsrc, nena) + sel_w(nclr);
  endfunction

endpackage

// File: rtl/ffre_lane.sv
// One programmable lane: config register, data flop, and the
// clear / enable / source decode that drives it.
module ffre_lane
  import ffre_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NSRC  = 3,
  parameter int NENA  = 5,
  parameter int NCLR  = 5,
  localparam int CFG_W = cfg_w(NSRC, NENA, NCLR)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NENA-1:0]       ena,
  input  logic [NCLR-1:0]       sclr,
  input  logic [NSRC*WIDTH-1:0] src,
  input  logic                  we,
  input  logic [CFG_W-1:0]      wdata,
  output logic [CFG_W-1:0]      cfg,
  output logic [WIDTH-1:0]      a,
  output logic                  upd,
  output logic                  load
);

  localparam int SW = sel_w(NSRC);
  localparam int EW = sel_w(NENA);
  localparam int CW = sel_w(NCLR);
  localparam int EN = 2 ** EW;
  localparam int CN = 2 ** CW;

  logic [SW-1:0]    src_sel;
  logic             ena_use;
  logic             ena_pol;
  logic [EW-1:0]    ena_sel;
  logic             clr_use;
  logic             clr_pol;
  logic [CW-1:0]    clr_sel;
  logic [EN-1:0]    ena_x;
  logic [CN-1:0]    sclr_x;
  logic             hit_clr;
  logic             en_ok;
  logic             src_ok;
  logic [WIDTH-1:0] sdata;

  assign src_sel = cfg[src_off() +: SW];
  assign ena_use = cfg[ena_use_off(NSRC)];
  assign ena_pol = cfg[ena_pol_off(NSRC)];
  assign ena_sel = cfg[ena_sel_off(NSRC) +: EW];
  assign clr_use = cfg[clr_use_off(NSRC, NENA)];
  assign clr_pol = cfg[clr_pol_off(NSRC, NENA)];
  assign clr_sel = cfg[clr_sel_off(NSRC, NENA) +: CW];

  // Zero-pad so every encodable select indexes a real bit; range checks gate use.
  assign ena_x  = EN'(ena);
  assign sclr_x = CN'(sclr);

  assign hit_clr = clr_use && (int'(clr_sel) < NCLR)
                && (sclr_x[clr_sel] == clr_pol);
  assign en_ok   = !ena_use || ((int'(ena_sel) < NENA)
                && (ena_x[ena_sel] == ena_pol));
  assign src_ok  = int'(src_sel) < NSRC;
  assign load    = !hit_clr && en_ok && src_ok;

  always_comb begin
    sdata = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (int'(src_sel) == s) sdata = src[s*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cfg <= '0;
      a   <= '0;
      upd <= 1'b0;
    end else begin
      if (we) cfg <= wdata;
      if (hit_clr) a <= '0;
      else if (load) a <= sdata;
      upd <= load;
    end
  end

endmodule

// File: rtl/ffre_bank.sv
// Programmable bank of register lanes with config readback and a
// saturating count of cycles in which any lane loaded.
module ffre_bank
  import ffre_pkg::*;
#(
  parameter int LANES = 8,
  parameter int WIDTH = 4,
  parameter int NSRC  = 3,
  parameter int NENA  = 5,
  parameter int NCLR  = 5,
  parameter int CNT_W = 16,
  localparam int LW    = sel_w(LANES),
  localparam int CFG_W = cfg_w(NSRC, NENA, NCLR)
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic [NENA-1:0]             ena,
  input  logic [NCLR-1:0]             sclr,
  input  logic [NSRC*LANES*WIDTH-1:0] din,
  input  logic                        cfg_we,
  input  logic [LW-1:0]               cfg_lane,
  input  logic [CFG_W-1:0]            cfg_wdata,
  output logic [CFG_W-1:0]            cfg_rdata,
  output logic [LANES*WIDTH-1:0]      a,
  output logic [LANES-1:0]            upd,
  output logic [CNT_W-1:0]            upd_cnt
);

  logic [CFG_W-1:0] cfgs [2**LW];
  logic [LANES-1:0] load;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [NSRC*WIDTH-1:0] lsrc;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
      assign lsrc[s*WIDTH +: WIDTH] = din[(s*LANES+l)*WIDTH +: WIDTH];
    end

    ffre_lane #(
      .WIDTH (WIDTH),
      .NSRC  (NSRC),
      .NENA  (NENA),
      .NCLR  (NCLR)
    ) u_lane (
      .clk   (clk),
      .clr   (clr),
      .ena   (ena),
      .sclr  (sclr),
      .src   (lsrc),
      .we    (cfg_we && (int'(cfg_lane) == l)),
      .wdata (cfg_wdata),
      .cfg   (cfgs[l]),
      .a     (a[l*WIDTH +: WIDTH]),
      .upd   (upd[l]),
      .load  (load[l])
    );
  end

  // Unpopulated addresses read back as zero.
  for (genvar l = LANES; l < 2**LW; l++) begin : g_pad
    assign cfgs[l] = '0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cfg_rdata <= '0;
      upd_cnt   <= '0;
    end else begin
      cfg_rdata <= cfgs[cfg_lane];
      if (|load && (upd_cnt != '1)) upd_cnt <= upd_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ffre_bank.sv
// Randomized and directed bench for ffre_bank against a behavioural
// model built from the lane rules and the config word layout.
module tb_ffre_bank;

  localparam int L  = 6;
  localparam int W  = 4;
  localparam int NS = 3;
  localparam int NE = 5;
  localparam int NC = 5;
  localparam int CB = 3;
  localparam int CMAX = (1 << CB) - 1;

  logic              clk = 1'b0;
  logic              clr;
  logic [NE-1:0]     ena;
  logic [NC-1:0]     sclr;
  logic [NS*L*W-1:0] din;
  logic              cfg_we;
  logic [2:0]        cfg_lane;
  logic [11:0]       cfg_wdata;
  logic [11:0]       cfg_rdata;
  logic [L*W-1:0]    a;
  logic [L-1:0]      upd;
  logic [CB-1:0]     upd_cnt;

  int m_cfg [L];
  int m_a   [L];
  int m_upd;
  int m_cnt;
  int m_rd;
  int n_chk = 0;
  int n_pass = 0;

  ffre_bank #(
    .LANES (L),
    .WIDTH (W),
    .NSRC  (NS),
    .NENA  (NE),
    .NCLR  (NC),
    .CNT_W (CB)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .ena       (ena),
    .sclr      (sclr),
    .din       (din),
    .cfg_we    (cfg_we),
    .cfg_lane  (cfg_lane),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .a         (a),
    .upd       (upd),
    .upd_cnt   (upd_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // src[2] eu[1] ep[1] es[3] cu[1] cp[1] cs[3], LSB first
  function automatic logic [11:0] mk(int src, int eu, int ep, int es,
                                     int cu, int cp, int cs);
    int v;
    v = src + eu * 4 + ep * 8 + es * 16 + cu * 128 + cp * 256 + cs * 512;
    return v[11:0];
  endfunction

  task automatic set_din(int s, int l, int v);
    logic [W-1:0] t;
    t = v[W-1:0];
    din[(s*L+l)*W +: W] = t;
  endtask

  function automatic int lane_out(int l);
    return int'(a[l*W +: W]);
  endfunction

  task automatic step();
    int na [L];
    int nu, any, w, src, eu, ep, es, cu, cp, cs;
    logic hit, en;
    logic [L*W-1:0] ea;
    nu = 0;
    any = 0;
    if (clr) begin
      for (int l = 0; l < L; l++) na[l] = 0;
    end else begin
      for (int l = 0; l < L; l++) begin
        w   = m_cfg[l];
        src = w % 4;
        eu  = (w / 4) % 2;
        ep  = (w / 8) % 2;
        es  = (w / 16) % 8;
        cu  = (w / 128) % 2;
        cp  = (w / 256) % 2;
        cs  = (w / 512) % 8;
        hit = 1'b0;
        if (cu == 1 && cs < NC) hit = (int'(sclr[cs]) == cp);
        en = (eu == 0);
        if (eu == 1 && es < NE) en = (int'(ena[es]) == ep);
        na[l] = m_a[l];
        if (hit) na[l] = 0;
        else if (en && src < NS) begin
          na[l] = int'(din[(src*L+l)*W +: W]);
          nu = nu | (1 << l);
          any = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (clr) begin
      for (int l = 0; l < L; l++) m_cfg[l] = 0;
      m_rd = 0;
      m_cnt = 0;
    end else begin
      m_rd = (cfg_lane < L) ? m_cfg[cfg_lane] : 0;
      if (any == 1 && m_cnt < CMAX) m_cnt++;
      if (cfg_we && cfg_lane < L) m_cfg[cfg_lane] = int'(cfg_wdata);
    end
    for (int l = 0; l < L; l++) begin
      m_a[l] = na[l];
      ea[l*W +: W] = na[l][W-1:0];
    end
    m_upd = nu;
    chk("a", 64'(a), 64'(ea));
    chk("upd", 64'(upd), 64'(m_upd));
    chk("upd_cnt", 64'(upd_cnt), 64'(m_cnt));
    chk("cfg_rdata", 64'(cfg_rdata), 64'(m_rd));
  endtask

  initial begin
    clr = 1'b1;
    ena = '0;
    sclr = '0;
    din = '0;
    cfg_we = 1'b0;
    cfg_lane = '0;
    cfg_wdata = '0;
    for (int l = 0; l < L; l++) begin
      m_cfg[l] = 0;
      m_a[l] = 0;
    end
    m_upd = 0;
    m_cnt = 0;
    m_rd = 0;
    #2;

    // reset default: every lane follows source 0
    step();
    step();
    chk("rst_a", 64'(a), 64'd0);
    chk("rst_cnt", 64'(upd_cnt), 64'd0);
    clr = 1'b0;
    for (int l = 0; l < L; l++) set_din(0, l, l);
    step();
    chk("t1_a", 64'(a), 64'h543210);
    chk("t1_upd", 64'(upd), 64'h3F);
    chk("t1_cnt", 64'(upd_cnt), 64'd1);

    // active-low enable on ena[2], source 1
    cfg_we = 1'b1;
    cfg_lane = 3'd3;
    cfg_wdata = mk(1, 1, 0, 2, 0, 0, 0);
    ena[2] = 1'b1;
    set_din(1, 3, 'hA);
    step();
    cfg_we = 1'b0;
    step();
    chk("t2_hold", 64'(lane_out(3)), 64'd3);
    chk("t2_hold_upd", 64'(upd[3]), 64'd0);
    ena[2] = 1'b0;
    step();
    chk("t2_load", 64'(lane_out(3)), 64'hA);
    chk("t2_load_upd", 64'(upd[3]), 64'd1);

    // lane clear beats an unconditional load
    cfg_we = 1'b1;
    cfg_lane = 3'd5;
    cfg_wdata = mk(0, 0, 0, 0, 1, 1, 4);
    step();
    cfg_we = 1'b0;
    sclr[4] = 1'b1;
    set_din(0, 5, 'hF);
    set_din(0, 4, 'hE);
    step();
    chk("t3_clr", 64'(lane_out(5)), 64'd0);
    chk("t3_clr_upd", 64'(upd[5]), 64'd0);
    chk("t3_other", 64'(lane_out(4)), 64'hE);
    sclr = '0;

    // write, read and load of lane 2 in one cycle
    cfg_we = 1'b1;
    cfg_lane = 3'd2;
    cfg_wdata = mk(2, 0, 0, 0, 0, 0, 0);
    set_din(0, 2, 1);
    set_din(2, 2, 7);
    step();
    chk("t4_old_src", 64'(lane_out(2)), 64'h1);
    chk("t4_old_rd", 64'(cfg_rdata), 64'd0);
    cfg_we = 1'b0;
    step();
    chk("t4_new_src", 64'(lane_out(2)), 64'h7);
    chk("t4_new_rd", 64'(cfg_rdata), 64'(mk(2, 0, 0, 0, 0, 0, 0)));

    // out-of-range source, lane address and enable select
    cfg_we = 1'b1;
    cfg_lane = 3'd0;
    cfg_wdata = mk(3, 0, 0, 0, 0, 0, 0);
    step();
    cfg_lane = 3'd7;
    cfg_wdata = 12'hFFF;
    step();
    cfg_lane = 3'd1;
    cfg_wdata = mk(0, 1, 0, 7, 0, 0, 0);
    step();
    cfg_we = 1'b0;
    set_din(0, 0, 9);
    set_din(0, 1, 9);
    step();
    chk("t5_upd", 64'(upd[1:0]), 64'd0);
    chk("t5_hold0", 64'(lane_out(0)), 64'd0);
    cfg_lane = 3'd7;
    step();
    chk("t5_rd_oor", 64'(cfg_rdata), 64'd0);

    // counter saturation, then a reset that beats a config write
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("t6_sat", 64'(upd_cnt), 64'(CMAX));
    clr = 1'b1;
    cfg_we = 1'b1;
    cfg_lane = 3'd0;
    cfg_wdata = 12'hABC;
    step();
    chk("t6_clr_a", 64'(a), 64'd0);
    chk("t6_clr_cnt", 64'(upd_cnt), 64'd0);
    clr = 1'b0;
    cfg_we = 1'b0;
    for (int l = 0; l < L; l++) begin
      cfg_lane = 3'(l);
      step();
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      clr = ($urandom_range(0, 99) < 3);
      ena = NE'($urandom);
      sclr = NC'($urandom);
      for (int s = 0; s < NS; s++)
        for (int l = 0; l < L; l++) set_din(s, l, $urandom_range(0, 15));
      cfg_we = ($urandom_range(0, 99) < 30);
      cfg_lane = 3'($urandom_range(0, 7));
      cfg_wdata = mk($urandom_range(0, 3), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 7),
                     ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                     $urandom_range(0, 7));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
